// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-channel synchroniser, debouncer and hold/auto-repeat
// pulse generator. All channels are identical and independent.
module key_debounce_multi #(
    parameter int unsigned NUM_KEYS      = 4,
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic [NUM_KEYS-1:0] keys_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_press,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_HOLDING   = 2'd1;
    localparam logic [1:0] ST_REPEATING = 2'd2;

    logic [NUM_KEYS-1:0] raw;
    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;

    assign raw = ACTIVE_LOW ? ~keys_in : keys_in;

    // Two-flop synchroniser for the asynchronous key pins
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        logic [DW-1:0] deb_cnt_q, deb_cnt_d;
        logic [HW-1:0] hold_cnt_q, hold_cnt_d;
        logic [RW-1:0] rep_cnt_q, rep_cnt_d;
        logic [1:0]    st_q, st_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          long_q, long_d;
        logic          rep_q, rep_d;

        // Debounce and hold/repeat next-state; a release always beats long/repeat
        always_comb begin
            deb_cnt_d  = deb_cnt_q;
            hold_cnt_d = hold_cnt_q;
            rep_cnt_d  = rep_cnt_q;
            st_d       = st_q;
            level_d    = level_q;
            press_d    = 1'b0;
            release_d  = 1'b0;
            long_d     = 1'b0;
            rep_d      = 1'b0;

            if (sync2_q[i] == level_q) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                level_d   = sync2_q[i];
                deb_cnt_d = '0;
                press_d   = sync2_q[i];
                release_d = ~sync2_q[i];
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end

            if (release_d) begin
                st_d       = ST_IDLE;
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
            end else begin
                case (st_q)
                    ST_IDLE: begin
                        if (press_d) begin
                            st_d       = ST_HOLDING;
                            hold_cnt_d = '0;
                        end
                    end
                    ST_HOLDING: begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            long_d    = 1'b1;
                            st_d      = ST_REPEATING;
                            rep_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HW'(1);
                        end
                    end
                    ST_REPEATING: begin
                        // With repeat disabled this state just parks until release
                        if (REPEAT_CYCLES != 0) begin
                            if (rep_cnt_q == REP_LAST) begin
                                rep_d     = 1'b1;
                                rep_cnt_d = '0;
                            end else begin
                                rep_cnt_d = rep_cnt_q + RW'(1);
                            end
                        end
                    end
                    default: st_d = ST_IDLE;
                endcase
            end
        end

        // Channel state registers
        always_ff @(posedge clk) begin
            if (rst) begin
                deb_cnt_q  <= '0;
                hold_cnt_q <= '0;
                rep_cnt_q  <= '0;
                st_q       <= ST_IDLE;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                long_q     <= 1'b0;
                rep_q      <= 1'b0;
            end else begin
                deb_cnt_q  <= deb_cnt_d;
                hold_cnt_q <= hold_cnt_d;
                rep_cnt_q  <= rep_cnt_d;
                st_q       <= st_d;
                level_q    <= level_d;
                press_q    <= press_d;
                release_q  <= release_d;
                long_q     <= long_d;
                rep_q      <= rep_d;
            end
        end

        assign keys_level[i]    = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_press[i]    = long_q;
        assign repeat_pulse[i]  = rep_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed literal checks plus randomized key
// activity compared every cycle against an event-level model.
module tb_key_debounce_multi;

    localparam int NK   = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] keys;
    logic [NK-1:0] keys_al;
    logic [NK-1:0] lvl, prs, rel, lng, rpt;
    logic [NK-1:0] a_lvl, a_prs, a_rel, a_lng, a_rpt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: delayed samples, accepted level, mismatch run length, press age
    logic [NK-1:0] m_s1, m_s2, m_lvl, m_prs, m_rel, m_lng, m_rpt;
    int            m_run [NK];
    int            m_age [NK];
    bit            m_held[NK];

    always #5 clk = ~clk;

    assign keys_al = ~keys;

    key_debounce_multi #(
        .NUM_KEYS(NK), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .keys_in(keys),
        .keys_level(lvl), .press_pulse(prs), .release_pulse(rel),
        .long_press(lng), .repeat_pulse(rpt)
    );

    key_debounce_multi #(
        .NUM_KEYS(NK), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst(rst), .keys_in(keys_al),
        .keys_level(a_lvl), .press_pulse(a_prs), .release_pulse(a_rel),
        .long_press(a_lng), .repeat_pulse(a_rpt)
    );

    task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    // Event-level reference: a level is accepted after DEB consecutive
    // disagreeing samples; long/repeat are pure functions of press age.
    task automatic model_step();
        for (int c = 0; c < NK; c++) begin
            m_prs[c] = 1'b0; m_rel[c] = 1'b0; m_lng[c] = 1'b0; m_rpt[c] = 1'b0;
            if (rst) begin
                m_lvl[c] = 1'b0; m_run[c] = 0; m_age[c] = 0; m_held[c] = 1'b0;
            end else begin
                if (m_s2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        m_lvl[c] = m_s2[c];
                        m_run[c] = 0;
                        if (m_s2[c]) m_prs[c] = 1'b1;
                        else         m_rel[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (m_rel[c]) begin
                    m_held[c] = 1'b0;
                end else if (m_held[c]) begin
                    m_age[c]++;
                    if (m_age[c] == HOLD) m_lng[c] = 1'b1;
                    else if (REP != 0 && m_age[c] > HOLD && (m_age[c] - HOLD) % REP == 0)
                        m_rpt[c] = 1'b1;
                end
                if (m_prs[c]) begin
                    m_held[c] = 1'b1;
                    m_age[c]  = 0;
                end
            end
        end
        m_s2 = rst ? '0 : m_s1;
        m_s1 = rst ? '0 : keys;
    endtask

    task automatic compare_all();
        chk("model_level",   lvl, m_lvl);
        chk("model_press",   prs, m_prs);
        chk("model_release", rel, m_rel);
        chk("model_long",    lng, m_lng);
        chk("model_repeat",  rpt, m_rpt);
        chk("al_level",      a_lvl, m_lvl);
        chk("al_press",      a_prs, m_prs);
        chk("al_release",    a_rel, m_rel);
        chk("al_long",       a_lng, m_lng);
        chk("al_repeat",     a_rpt, m_rpt);
    endtask

    // One clock: inputs are stable across the edge, outputs sampled at negedge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    int left[NK];

    initial begin
        m_s1 = '0; m_s2 = '0; m_lvl = '0;
        for (int c = 0; c < NK; c++) begin
            m_run[c] = 0; m_age[c] = 0; m_held[c] = 1'b0;
        end
        rst  = 1'b1;
        keys = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_level", lvl, 4'b0000);
        chk("reset_pulses", prs | rel | lng | rpt, 4'b0000);

        // Clean press on key2, hold through long press and repeats
        keys = 4'b0100;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 6) chk("A_no_early_press", prs, 4'b0000);
        end
        chk("A_press", prs, 4'b0100);
        chk("A_level", lvl, 4'b0100);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("A_long", lng, (i == 10) ? 4'b0100 : 4'b0000);
        end
        for (int r = 0; r < 3; r++)
            for (int i = 1; i <= 3; i++) begin
                tick();
                chk("A_repeat", rpt, (i == 3) ? 4'b0100 : 4'b0000);
            end
        // Release lands on the cycle a repeat would fire: release wins
        keys = 4'b0000;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("A_rel_repeat", rpt, (i == 3) ? 4'b0100 : 4'b0000);
            chk("A_release", rel, (i == 6) ? 4'b0100 : 4'b0000);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("A_quiet_after_release", rpt | lng, 4'b0000);
        end

        // Key1 bounce: 2-cycle glitches never accepted
        for (int ph = 0; ph < 4; ph++) begin
            keys = (ph % 2 == 0) ? 4'b0010 : 4'b0000;
            repeat (2) begin
                tick();
                chk("B_bounce_no_press", prs, 4'b0000);
            end
        end
        keys = 4'b0010;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("B_press", prs, (i == 6) ? 4'b0010 : 4'b0000);
        end
        keys = 4'b0000;
        repeat (12) tick();

        // Key3 released 8 cycles after press: no long press ever
        keys = 4'b1000;
        repeat (6) tick();
        chk("C_press", prs, 4'b1000);
        repeat (2) tick();
        keys = 4'b0000;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("C_release", rel, (i == 6) ? 4'b1000 : 4'b0000);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("C_no_long", lng, 4'b0000);
        end

        // All keys together, then reset mid-hold
        keys = 4'b1111;
        repeat (6) tick();
        chk("D_press_all", prs, 4'b1111);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("D_rst_level", lvl, 4'b0000);
        chk("D_rst_pulses", prs | rel | lng | rpt, 4'b0000);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("D_repress", prs, (i == 6) ? 4'b1111 : 4'b0000);
        end
        keys = 4'b0000;
        repeat (10) tick();

        // Active-low instance: its pin for key0 falls while others stay high
        keys = 4'b0001;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("E_al_press", a_prs, (i == 6) ? 4'b0001 : 4'b0000);
        end
        chk("E_al_level", a_lvl, 4'b0001);
        keys = 4'b0000;
        repeat (10) tick();

        // Randomized activity: mix of glitches and long holds, rare resets
        for (int c = 0; c < NK; c++) left[c] = $urandom_range(1, 20);
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NK; c++) begin
                left[c]--;
                if (left[c] <= 0) begin
                    keys[c] = ~keys[c];
                    if ($urandom_range(0, 2) == 0) left[c] = $urandom_range(1, 4);
                    else                           left[c] = $urandom_range(5, 45);
                end
            end
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Parametrised multi-channel key conditioner. Each channel synchronises a raw key input, debounces it, and reports the stable level plus single-cycle press, release, long-press and auto-repeat pulses. It sits between the board key pins and the game/menu control logic, replacing per-key ad-hoc debouncers. All channels are identical and fully independent.

Parameters:
NUM_KEYS, 4, number of independent key channels (>=1)
DEB_CYCLES, 500000, consecutive stable synchronised samples required to accept a level change (>=1)
HOLD_CYCLES, 50000000, cycles a key must stay debounced-pressed before long_press fires (>=1)
REPEAT_CYCLES, 10000000, auto-repeat period after long_press; 0 disables repeat
ACTIVE_LOW, 0, 1 = raw key reads 0 when pressed (input inverted before synchroniser)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
keys_in  input  NUM_KEYS  raw asynchronous key inputs
keys_level  output  NUM_KEYS  debounced level, 1 = pressed
press_pulse  output  NUM_KEYS  one-cycle pulse on accepted press
release_pulse  output  NUM_KEYS  one-cycle pulse on accepted release
long_press  output  NUM_KEYS  one-cycle pulse after HOLD_CYCLES of continuous press
repeat_pulse  output  NUM_KEYS  one-cycle pulse every REPEAT_CYCLES after long_press while held

Behaviour:
- Reset: one clock, reset is synchronous and active-high (clk, rst); on rst high at a clk edge, all outputs, synchroniser flops, debounce counters and hold/repeat counters go to 0. Keys are treated as released after reset; a key held through reset is re-debounced normally after rst falls.
- Input path per channel: optional inversion (ACTIVE_LOW), then 2-flop synchroniser; s = second flop output.
- Debounce counter deb_cnt (width ceil(log2(DEB_CYCLES+1)), derived internally): if s == keys_level, deb_cnt <= 0; else deb_cnt <= deb_cnt+1, and when deb_cnt == DEB_CYCLES-1 the channel instead sets keys_level <= s, deb_cnt <= 0.
- Any sample with s == keys_level before acceptance restarts the count (glitch rejection); no partial credit.
- Latency: keys_level changes on the (DEB_CYCLES+2)-th clk edge after a clean raw input edge. press_pulse/release_pulse are high in exactly the cycle keys_level first shows the new value; never both in one cycle.
- Per-channel hold FSM: IDLE (released) -> HOLDING on accepted press; HOLDING -> REPEATING when hold_cnt reaches HOLD_CYCLES-1 (long_press high that cycle, once per press); REPEATING emits repeat_pulse every REPEAT_CYCLES cycles, first one REPEAT_CYCLES cycles after long_press; if REPEAT_CYCLES == 0 REPEATING is a quiet saturated state. Any state -> IDLE on accepted release, counters cleared, no further long/repeat pulses.
- hold_cnt starts at 0 in the cycle after press_pulse and counts only in HOLDING; long_press occurs HOLD_CYCLES cycles after press_pulse. Counters never wrap.
- Release accepted in the same cycle hold_cnt would fire: release wins, no long_press. Release in the cycle a repeat would fire: release wins.
- Channels never interact; simultaneous events on different channels are all reported in the same cycle.

Test Plan:
(Bench params: NUM_KEYS=4, DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=0.)
- Clean press key0 at edge t -> keys_level[0]=1 and press_pulse[0]=1 for one cycle at edge t+6; other channels stay 0.
- Key1 bouncing 1,0,1,0 each 2 cycles then steady 1 -> no press_pulse during bounce; single press_pulse 6 edges after final rising edge.
- Hold key2 -> long_press[2] 10 cycles after press_pulse, repeat_pulse[2] at +3, +6, +9 after that; release -> release_pulse[2], repeats stop.
- Key3 released 8 cycles after press_pulse (before HOLD) -> release_pulse only, no long_press ever.
- All four keys pressed same edge -> press_pulse=4'b1111 in one cycle; assert rst mid-hold -> all outputs 0 next edge, press re-reported 6 edges after rst low.
- Rebuild ACTIVE_LOW=1, drive keys_in=4'b1111 idle, key0 to 0 -> press_pulse[0] after 6 edges.
